multi_byte_store_fsm: RTL and testbench
=======================================

Name: multi_byte_store_fsm

Overview:
- Write-side counterpart of the CPU's multi-byte instruction/operand fetch sequencer.
- Takes a 1-3 byte value and a base address, and emits it to memory one byte at a time over the CPU memory bus.
- Sequencing is LATCH_ADDRESS / WRITE_BYTE / CHK_MORE_BYTES, the write-direction mirror of the fetch flow.
- Used by the control unit for 16-bit stores and for stack pushes (return address, status); sits between u_control_unit and the cpu_mem_* bus.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 8, bus byte width.
- MAX_BYTES, 3, maximum bytes per store (value width = MAX_BYTES*DATA_WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle request; sampled only in IDLE.
- byte_count  input  2  number of bytes to write, valid 1..MAX_BYTES.
- stack_mode  input  1  0 = ascending little-endian store; 1 = descending push.
- base_addr  input  ADDR_WIDTH  first address written.
- data_in  input  MAX_BYTES*DATA_WIDTH  value; byte0 = [7:0].
- mem_wait  input  1  memory stall; holds WRITE_BYTE while 1.
- mem_address  output  ADDR_WIDTH  bus address (= internal addr_reg).
- mem_write  output  1  write strobe.
- mem_data_out  output  DATA_WIDTH  byte being written.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle completion pulse.
- end_addr  output  ADDR_WIDTH  address following the last byte written (new SP in push mode).

Behaviour:
- Reset (reset=0, async): state=IDLE; addr_reg, mem_data_out, end_addr = 0; mem_write, busy, done = 0. Takes effect immediately, including mid-write: mem_write drops without waiting for a clock edge. The store is abandoned and no done is issued.
- IDLE:
  - start=1 with byte_count in 1..MAX_BYTES: latch base_addr into addr_reg, data_in into data_reg, byte_count into remaining; set byte index = 0 (stack_mode=0) or byte_count-1 (stack_mode=1); go to LATCH_ADDRESS.
  - start=1 with byte_count=0 or >MAX_BYTES: ignored; stay in IDLE, no done.
- LATCH_ADDRESS: mem_address=addr_reg, mem_write=0; go to WRITE_BYTE.
- WRITE_BYTE: mem_write=1; mem_data_out = data_reg byte[index].
  - mem_wait=1: stay; outputs held stable.
  - mem_wait=0, on exit edge: addr_reg +1 (mode 0) or -1 (mode 1); remaining -1; index +1 (mode 0) or -1 (mode 1); go to CHK_MORE_BYTES.
- CHK_MORE_BYTES: mem_write=0; remaining!=0 -> LATCH_ADDRESS; otherwise end_addr=addr_reg and go to DONE.
- DONE: done=1 for exactly one cycle, busy=1; then IDLE.
- Latency: with no stalls, done is high in cycle 3N+1 after the start-sampling edge (N = byte_count). Each mem_wait cycle adds one cycle.
- start while busy: ignored; no queueing.
- Address arithmetic is modulo 2^ADDR_WIDTH: FFFF+1 -> 0000; 0000-1 -> FFFF. No error flag.
- data_in, base_addr, byte_count and stack_mode are don't-care after the start-sampling edge; the latched copies are used.
- Exactly one mem_write-high interval per byte; never two consecutive bytes without an intervening mem_write=0 cycle.

Test Plan:
- Reset; start, byte_count=2, stack_mode=0, base_addr=2000, data_in=001234 -> 2000<=34 then 2001<=12; mem_write high in cycles 2 and 5; done in cycle 7; end_addr=2002.
- Push: byte_count=2, stack_mode=1, base_addr=01FF, data_in=00F003 -> 01FF<=F0, 01FE<=03; end_addr=01FD; RAM readback matches.
- byte_count=3, mode 0, base_addr=FFFE, data_in=ABCDEF -> FFFE<=EF, FFFF<=CD, 0000<=AB (wrap); end_addr=0001; done in cycle 10.
- mem_wait=1 for 2 cycles during the first WRITE_BYTE of a 1-byte store (base 3000, data 55) -> mem_write held 3 cycles, address/data stable, single write of 55 at 3000; done in cycle 6.
- Stray-request and reset checks:
  - byte_count=0 -> busy stays 0, no done, no write.
  - start pulsed mid-store -> ignored.
  - reset=0 asserted mid-WRITE_BYTE -> mem_write falls before the next edge, busy=0, no done.

Source files
------------

// File: rtl/multi_byte_store_fsm.sv
// multi_byte_store_fsm: writes a 1..MAX_BYTES value to memory one byte per bus write (ascending store or descending push); ports: clk, reset(async active-low), start/byte_count/stack_mode/base_addr/data_in request, mem_wait stall, mem_address/mem_write/mem_data_out bus, busy/done/end_addr status
module multi_byte_store_fsm #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BYTES  = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [1:0]                      byte_count,
  input  logic                            stack_mode,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [MAX_BYTES*DATA_WIDTH-1:0] data_in,
  input  logic                            mem_wait,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic                            mem_write,
  output logic [DATA_WIDTH-1:0]           mem_data_out,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_WIDTH-1:0]           end_addr
);
  localparam int IW = MAX_BYTES > 1 ? $clog2(MAX_BYTES) : 1;
  typedef enum logic [2:0] {IDLE, LATCH_ADDRESS, WRITE_BYTE, CHK_MORE_BYTES, DONE} state_t;
  state_t state, next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [MAX_BYTES-1:0][DATA_WIDTH-1:0] data_reg;
  logic [1:0] remaining;
  logic [IW-1:0] idx;
  logic mode;
  logic accept;
  logic step;
  assign accept = start && byte_count != 2'd0 && 32'(byte_count) <= MAX_BYTES;
  assign step = state == WRITE_BYTE && !mem_wait;
  assign mem_address = addr_reg;
  assign mem_write = state == WRITE_BYTE;
  assign mem_data_out = data_reg[idx];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:           next = accept ? LATCH_ADDRESS : IDLE;
      LATCH_ADDRESS:  next = WRITE_BYTE;
      WRITE_BYTE:     next = mem_wait ? WRITE_BYTE : CHK_MORE_BYTES;
      CHK_MORE_BYTES: next = remaining != 2'd0 ? LATCH_ADDRESS : DONE;
      default:        next = IDLE;
    endcase
  end
  // idx only moves while more bytes remain, so it never leaves 0..MAX_BYTES-1
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      addr_reg <= '0;
      data_reg <= '0;
      remaining <= '0;
      idx <= '0;
      mode <= 1'b0;
      end_addr <= '0;
    end else if (state == IDLE && accept) begin
      addr_reg <= base_addr;
      data_reg <= data_in;
      remaining <= byte_count;
      mode <= stack_mode;
      idx <= stack_mode ? IW'(byte_count - 2'd1) : '0;
    end else if (step) begin
      addr_reg <= mode ? addr_reg - ADDR_WIDTH'(1) : addr_reg + ADDR_WIDTH'(1);
      remaining <= remaining - 2'd1;
      if (remaining > 2'd1) idx <= mode ? idx - IW'(1) : idx + IW'(1);
    end else if (state == CHK_MORE_BYTES && remaining == 2'd0) begin
      end_addr <= addr_reg;
    end
endmodule

// File: tb/tb_multi_byte_store_fsm.sv
// tb_multi_byte_store_fsm: table-driven check of multi_byte_store_fsm plus reset corner sequences
module tb_multi_byte_store_fsm;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [1:0] byte_count = '0;
  logic stack_mode = 1'b0;
  logic [15:0] base_addr = '0;
  logic [23:0] data_in = '0;
  logic mem_wait = 1'b0;
  logic [15:0] mem_address;
  logic mem_write;
  logic [7:0] mem_data_out;
  logic busy;
  logic done;
  logic [15:0] end_addr;
  int tests = 0;
  int fails = 0;
  logic [7:0] ram [logic [15:0]];

  multi_byte_store_fsm dut (
    .clk(clk), .reset(reset), .start(start), .byte_count(byte_count),
    .stack_mode(stack_mode), .base_addr(base_addr), .data_in(data_in),
    .mem_wait(mem_wait), .mem_address(mem_address), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .busy(busy), .done(done), .end_addr(end_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] bc;
    logic m;
    logic [15:0] base;
    logic [23:0] data;
    int wl;
    int stray;
    int n;
    logic [2:0][15:0] wa;
    logic [2:0][7:0] wd;
    logic [15:0] ea;
    int dc;
  } vec_t;

  function automatic vec_t mk(logic [1:0] bc, logic m, logic [15:0] base, logic [23:0] data,
                              int wl, int stray, int n, logic [47:0] wa, logic [23:0] wd,
                              logic [15:0] ea, int dc);
    vec_t v;
    v.bc = bc; v.m = m; v.base = base; v.data = data; v.wl = wl; v.stray = stray;
    v.n = n; v.wa = wa; v.wd = wd; v.ea = ea; v.dc = dc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(int k, vec_t v);
    logic [15:0] ga [4];
    logic [7:0] gd [4];
    int gc [4];
    int gl [4];
    int n = 0;
    int dcount = 0;
    int dcyc = 0;
    int busy_err = 0;
    int stab_err = 0;
    logic prev = 1'b0;
    int lim = v.dc > 0 ? v.dc + 2 : 15;
    @(negedge clk);
    start = 1'b1; byte_count = v.bc; stack_mode = v.m; base_addr = v.base; data_in = v.data; mem_wait = 1'b0;
    for (int cyc = 1; cyc <= lim; cyc++) begin
      @(negedge clk);
      start = cyc == v.stray;
      byte_count = 2'd3; base_addr = 16'hDEAD; data_in = 24'h5A5A5A; stack_mode = ~v.m;
      mem_wait = v.wl > 0 && cyc >= 2 && cyc < 2 + v.wl;
      if (mem_write) ram[mem_address] = mem_data_out;
      if (mem_write && !prev && n < 4) begin
        ga[n] = mem_address; gd[n] = mem_data_out; gc[n] = cyc; gl[n] = 1; n++;
      end else if (mem_write && prev && n > 0) begin
        gl[n-1]++;
        if (mem_address !== ga[n-1] || mem_data_out !== gd[n-1]) stab_err++;
      end
      prev = mem_write;
      if (done) begin dcount++; dcyc = cyc; end
      if (busy !== (cyc <= v.dc)) busy_err++;
    end
    start = 1'b0; mem_wait = 1'b0;
    chk($sformatf("v%0d writes", k), n, v.n);
    for (int i = 0; i < v.n && i < n; i++) begin
      chk($sformatf("v%0d w%0d addr", k, i), ga[i], v.wa[i]);
      chk($sformatf("v%0d w%0d data", k, i), gd[i], v.wd[i]);
      chk($sformatf("v%0d w%0d cycle", k, i), gc[i], 2 + 3 * i + (i > 0 ? v.wl : 0));
      chk($sformatf("v%0d w%0d len", k, i), gl[i], i == 0 ? 1 + v.wl : 1);
      chk($sformatf("v%0d ram%0d", k, i), ram[v.wa[i]], v.wd[i]);
    end
    chk($sformatf("v%0d done count", k), dcount, v.dc > 0 ? 1 : 0);
    chk($sformatf("v%0d done cycle", k), dcyc, v.dc);
    chk($sformatf("v%0d busy", k), busy_err, 0);
    chk($sformatf("v%0d stable", k), stab_err, 0);
    if (v.n > 0) chk($sformatf("v%0d end_addr", k), end_addr, v.ea);
  endtask

  initial begin
    vec_t tv [8];
    int bad;
    tv[0] = mk(2'd2, 1'b0, 16'h2000, 24'h001234, 0, 0, 2, {16'h0, 16'h2001, 16'h2000}, {8'h0, 8'h12, 8'h34}, 16'h2002, 7);
    tv[1] = mk(2'd2, 1'b1, 16'h01FF, 24'h00F003, 0, 0, 2, {16'h0, 16'h01FE, 16'h01FF}, {8'h0, 8'h03, 8'hF0}, 16'h01FD, 7);
    tv[2] = mk(2'd3, 1'b0, 16'hFFFE, 24'hABCDEF, 0, 0, 3, {16'h0000, 16'hFFFF, 16'hFFFE}, {8'hAB, 8'hCD, 8'hEF}, 16'h0001, 10);
    tv[3] = mk(2'd1, 1'b0, 16'h3000, 24'h000055, 2, 0, 1, {16'h0, 16'h0, 16'h3000}, {8'h0, 8'h0, 8'h55}, 16'h3001, 6);
    tv[4] = mk(2'd3, 1'b1, 16'h0001, 24'h112233, 0, 0, 3, {16'hFFFF, 16'h0000, 16'h0001}, {8'h33, 8'h22, 8'h11}, 16'hFFFE, 10);
    tv[5] = mk(2'd0, 1'b0, 16'h7000, 24'h123456, 0, 0, 0, '0, '0, 16'h0, 0);
    tv[6] = mk(2'd2, 1'b0, 16'h4000, 24'h00A5B6, 0, 3, 2, {16'h0, 16'h4001, 16'h4000}, {8'h0, 8'hA5, 8'hB6}, 16'h4002, 7);
    tv[7] = mk(2'd1, 1'b1, 16'h8000, 24'h0000C7, 0, 0, 1, {16'h0, 16'h0, 16'h8000}, {8'h0, 8'h0, 8'hC7}, 16'h7FFF, 4);
    repeat (2) @(negedge clk);
    chk("rst mem_address", mem_address, 16'h0);
    chk("rst mem_write", mem_write, 1'b0);
    chk("rst mem_data_out", mem_data_out, 8'h0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst end_addr", end_addr, 16'h0);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) run_vec(k, tv[k]);
    @(negedge clk);
    start = 1'b1; byte_count = 2'd2; stack_mode = 1'b0; base_addr = 16'h6000; data_in = 24'h00C3D4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid mem_write before reset", mem_write, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid mem_write", mem_write, 1'b0);
    chk("mid busy", busy, 1'b0);
    chk("mid done", done, 1'b0);
    chk("mid mem_address", mem_address, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || mem_write || busy) bad++;
    end
    chk("after reset quiet", bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
